control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/tron_ctrl_pkg.sv | 111 +++++++++++
 rtl/instr_decode.sv | 108 ++++++++++
 rtl/control_fsm.sv | 119 +++++++++++
 tb/tb_control_fsm.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tron_ctrl_pkg.sv
// rtl/tron_ctrl_pkg.sv - shared encodings and control bundle for the TRON control path
//
// Purpose: the FSM state enum, instruction opcode/opext constants, the
// datapath select encodings (ALUOp, busOp, shiftOp, flagOp condition codes)
// and the control bundle that instr_decode hands to control_fsm.
// Ports: none (package).

package tron_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_t;

   // Primary opcodes, IR[15:12]
   localparam logic [3:0] OP_RTYPE   = 4'b0000;
   localparam logic [3:0] OP_ANDI    = 4'b0001;
   localparam logic [3:0] OP_ORI     = 4'b0010;
   localparam logic [3:0] OP_XORI    = 4'b0011;
   localparam logic [3:0] OP_SPECIAL = 4'b0100;
   localparam logic [3:0] OP_ADDI    = 4'b0101;
   localparam logic [3:0] OP_SHIFT   = 4'b1000;
   localparam logic [3:0] OP_SUBI    = 4'b1001;
   localparam logic [3:0] OP_CMPI    = 4'b1011;
   localparam logic [3:0] OP_BCOND   = 4'b1100;
   localparam logic [3:0] OP_MOVI    = 4'b1101;
   localparam logic [3:0] OP_LUI     = 4'b1111;

   // Opcode extensions, IR[7:4], under OP_SPECIAL
   localparam logic [3:0] EXT_LOAD   = 4'b0000;
   localparam logic [3:0] EXT_STOR   = 4'b0100;
   localparam logic [3:0] EXT_JAL    = 4'b1000;
   localparam logic [3:0] EXT_JCOND  = 4'b1100;

   // Opcode extensions under OP_SHIFT; for the immediate forms the low bit
   // is the sign (direction) of the shift amount held in IR[3:0].
   localparam logic [3:0] EXT_LSHI_L  = 4'b0000;
   localparam logic [3:0] EXT_LSHI_R  = 4'b0001;
   localparam logic [3:0] EXT_ASHUI_L = 4'b0010;
   localparam logic [3:0] EXT_ASHUI_R = 4'b0011;
   localparam logic [3:0] EXT_LSH     = 4'b0100;
   localparam logic [3:0] EXT_ASHU    = 4'b0110;

   // ALU operations share the numbering of R-type opext and I-type opcode
   localparam logic [3:0] ALU_NONE = 4'b0000;
   localparam logic [3:0] ALU_AND  = 4'b0001;
   localparam logic [3:0] ALU_OR   = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_ADD  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b1001;
   localparam logic [3:0] ALU_CMP  = 4'b1011;
   localparam logic [3:0] ALU_MOV  = 4'b1101;

   localparam logic [2:0] BUS_ALU   = 3'd0;
   localparam logic [2:0] BUS_SHIFT = 3'd1;
   localparam logic [2:0] BUS_MEM   = 3'd2;
   localparam logic [2:0] BUS_IMM   = 3'd3;
   localparam logic [2:0] BUS_PC    = 3'd4;

   localparam logic [1:0] SHIFT_LSH   = 2'b00;
   localparam logic [1:0] SHIFT_LSHI  = 2'b01;
   localparam logic [1:0] SHIFT_ASHU  = 2'b10;
   localparam logic [1:0] SHIFT_ASHUI = 2'b11;

   // Condition codes, carried verbatim in IR[11:8] of Bcond/Jcond
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_GT = 4'b0110;
   localparam logic [3:0] COND_LT = 4'b1100;
   localparam logic [3:0] COND_GE = 4'b1101;
   localparam logic [3:0] COND_UC = 4'b1110;

   typedef struct packed {
      logic [3:0] alu_op;
      logic [1:0] shift_op;
      logic [2:0] bus_op;
      logic [3:0] flag_op;
      logic       imm_mux;
      logic       lui_op;
      logic       reg_write;
      logic       mem_write;
      logic       flag_write;
      logic       pc_add;
      logic       pc_jump;
      logic       pc_branch;
      logic       addr_sel;
   } ctrl_t;

   function automatic logic is_alu_code(input logic [3:0] code);
      return code inside {ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SUB, ALU_CMP, ALU_MOV};
   endfunction

   // Bundle for a register/immediate ALU instruction; compares only set flags.
   function automatic ctrl_t alu_ctrl(input logic [3:0] code, input logic imm);
      ctrl_t c;
      c            = '0;
      c.alu_op     = code;
      c.bus_op     = BUS_ALU;
      c.imm_mux    = imm;
      c.reg_write  = (code != ALU_CMP);
      c.flag_write = code inside {ALU_ADD, ALU_SUB, ALU_CMP};
      c.pc_add     = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational IR to EXEC-cycle control bundle
//
// Purpose: decodes the held instruction word into the strobes driven during
// EXEC, and flags LOAD so the FSM can take the MEM/WB path.
// Ports:
//   ir      in   16  instruction register
//   ctrl    out  ctrl_t  EXEC-cycle control bundle
//   is_load out  1   instruction continues through MEM and WB
// Configuration: TRON_JAL_EN enables JAL; otherwise JAL decodes as a NOP.

module instr_decode
   import tron_ctrl_pkg::*;
(
   input  logic [15:0] ir,
   output ctrl_t       ctrl,
   output logic        is_load
);

   logic [3:0] opcode;
   logic [3:0] opext;

   assign opcode = ir[15:12];
   assign opext  = ir[7:4];

   always_comb begin
      ctrl        = '0;
      ctrl.pc_add = 1'b1;   // anything not matched below retires as a NOP
      is_load     = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            if (is_alu_code(opext)) ctrl = alu_ctrl(opext, 1'b0);
         end
         OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI: begin
            ctrl = alu_ctrl(opcode, 1'b1);
         end
         OP_LUI: begin
            ctrl.bus_op    = BUS_IMM;
            ctrl.lui_op    = 1'b1;
            ctrl.imm_mux   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         OP_SHIFT: begin
            case (opext)
               EXT_LSHI_L, EXT_LSHI_R: begin
                  ctrl.shift_op  = SHIFT_LSHI;
                  ctrl.imm_mux   = 1'b1;
                  ctrl.bus_op    = BUS_SHIFT;
                  ctrl.reg_write = 1'b1;
               end
               EXT_ASHUI_L, EXT_ASHUI_R: begin
                  ctrl.shift_op  = SHIFT_ASHUI;
                  ctrl.imm_mux   = 1'b1;
                  ctrl.bus_op    = BUS_SHIFT;
                  ctrl.reg_write = 1'b1;
               end
               EXT_LSH: begin
                  ctrl.shift_op  = SHIFT_LSH;
                  ctrl.bus_op    = BUS_SHIFT;
                  ctrl.reg_write = 1'b1;
               end
               EXT_ASHU: begin
                  ctrl.shift_op  = SHIFT_ASHU;
                  ctrl.bus_op    = BUS_SHIFT;
                  ctrl.reg_write = 1'b1;
               end
               default: ;
            endcase
         end
         OP_BCOND: begin
            ctrl.pc_add    = 1'b0;
            ctrl.flag_op   = ir[11:8];
            ctrl.pc_branch = 1'b1;
         end
         OP_SPECIAL: begin
            case (opext)
               EXT_LOAD: begin
                  // Only the address is driven here; the write happens in WB.
                  ctrl.pc_add   = 1'b0;
                  ctrl.addr_sel = 1'b1;
                  is_load       = 1'b1;
               end
               EXT_STOR: begin
                  ctrl.addr_sel  = 1'b1;
                  ctrl.mem_write = 1'b1;
               end
               EXT_JCOND: begin
                  ctrl.pc_add  = 1'b0;
                  ctrl.flag_op = ir[11:8];
                  ctrl.pc_jump = 1'b1;
               end
`ifdef TRON_JAL_EN
               EXT_JAL: begin
                  // Link: current PC goes to Rdest while the PC takes regA.
                  ctrl.pc_add    = 1'b0;
                  ctrl.bus_op    = BUS_PC;
                  ctrl.reg_write = 1'b1;
                  ctrl.pc_jump   = 1'b1;
                  ctrl.flag_op   = COND_UC;
               end
`endif
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multi-cycle Moore control FSM for the TRON datapath
//
// Purpose: sequences FETCH/DECODE/EXEC (plus MEM/WB for LOAD), holds the
// instruction register and counts retired instructions.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   memData        in   16  instruction word, valid in DECODE
//   instructionOp  out  8   {IR[15:12], IR[7:4]}
//   immediate      out  8   IR[7:0]
//   regAddA/B      out  4   IR[3:0] (Rsrc) / IR[11:8] (Rdest)
//   ALUOp, shiftOp, busOp, flagOp    datapath selects
//   immMUX, LUIOp, regWrite, memWrite, flagWrite, pcAdd, pcJump, pcBranch  strobes
//   addrSel        out  1   memory address source, 0 = PC, 1 = regA
//   retired        out  16  completed instruction count
// Configuration: TRON_JAL_EN (see instr_decode) enables JAL.

module control_fsm
   import tron_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] memData,
   output logic [7:0]  instructionOp,
   output logic [7:0]  immediate,
   output logic [3:0]  regAddA,
   output logic [3:0]  regAddB,
   output logic [3:0]  ALUOp,
   output logic [1:0]  shiftOp,
   output logic [2:0]  busOp,
   output logic [3:0]  flagOp,
   output logic        immMUX,
   output logic        LUIOp,
   output logic        regWrite,
   output logic        memWrite,
   output logic        flagWrite,
   output logic        pcAdd,
   output logic        pcJump,
   output logic        pcBranch,
   output logic        addrSel,
   output logic [15:0] retired
);

   state_t      state;
   state_t      next_state;
   logic [15:0] ir;
   ctrl_t       dec;
   logic        dec_load;
   ctrl_t       ctl;
   logic        instr_done;

   instr_decode u_decode (
      .ir      (ir),
      .ctrl    (dec),
      .is_load (dec_load)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_FETCH;
      else        state <= next_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 ir <= '0;
      else if (state == ST_DECODE) ir <= memData;
   end

   always_comb begin
      next_state = ST_FETCH;
      case (state)
         ST_FETCH:  next_state = ST_DECODE;
         ST_DECODE: next_state = ST_EXEC;
         ST_EXEC:   next_state = dec_load ? ST_MEM : ST_FETCH;
         ST_MEM:    next_state = ST_WB;
         ST_WB:     next_state = ST_FETCH;
         default:   next_state = ST_FETCH;
      endcase
   end

   always_comb begin
      ctl = '0;
      case (state)
         ST_EXEC: ctl = dec;
         ST_MEM:  ctl.addr_sel = 1'b1;
         ST_WB: begin
            ctl.bus_op    = BUS_MEM;
            ctl.reg_write = 1'b1;
            ctl.pc_add    = 1'b1;
         end
         default: ;
      endcase
   end

   // Every instruction ends with exactly one PC update, so that marks retirement.
   assign instr_done = ctl.pc_add | ctl.pc_jump | ctl.pc_branch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          retired <= '0;
      else if (instr_done) retired <= retired + 16'd1;
   end

   assign instructionOp = {ir[15:12], ir[7:4]};
   assign immediate     = ir[7:0];
   assign regAddA       = ir[3:0];
   assign regAddB       = ir[11:8];
   assign ALUOp         = ctl.alu_op;
   assign shiftOp       = ctl.shift_op;
   assign busOp         = ctl.bus_op;
   assign flagOp        = ctl.flag_op;
   assign immMUX        = ctl.imm_mux;
   assign LUIOp         = ctl.lui_op;
   assign regWrite      = ctl.reg_write;
   assign memWrite      = ctl.mem_write;
   assign flagWrite     = ctl.flag_write;
   assign pcAdd         = ctl.pc_add;
   assign pcJump        = ctl.pc_jump;
   assign pcBranch      = ctl.pc_branch;
   assign addrSel       = ctl.addr_sel;

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - scoreboard bench for control_fsm
`timescale 1ns/1ps

module tb_control_fsm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] memData = 16'h0000;
   logic [7:0]  instructionOp;
   logic [7:0]  immediate;
   logic [3:0]  regAddA;
   logic [3:0]  regAddB;
   logic [3:0]  ALUOp;
   logic [1:0]  shiftOp;
   logic [2:0]  busOp;
   logic [3:0]  flagOp;
   logic        immMUX;
   logic        LUIOp;
   logic        regWrite;
   logic        memWrite;
   logic        flagWrite;
   logic        pcAdd;
   logic        pcJump;
   logic        pcBranch;
   logic        addrSel;
   logic [15:0] retired;

   control_fsm dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .memData       (memData),
      .instructionOp (instructionOp),
      .immediate     (immediate),
      .regAddA       (regAddA),
      .regAddB       (regAddB),
      .ALUOp         (ALUOp),
      .shiftOp       (shiftOp),
      .busOp         (busOp),
      .flagOp        (flagOp),
      .immMUX        (immMUX),
      .LUIOp         (LUIOp),
      .regWrite      (regWrite),
      .memWrite      (memWrite),
      .flagWrite     (flagWrite),
      .pcAdd         (pcAdd),
      .pcJump        (pcJump),
      .pcBranch      (pcBranch),
      .addrSel       (addrSel),
      .retired       (retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] word;
      int          lat;
      logic [4:0]  amask;   // expected addrSel per non-final cycle index
      logic [21:0] ctl;     // expected outputs in the final cycle
      logic [15:0] ret;     // retired value seen during the final cycle
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] model_ret = 16'h0000;
   int          idx = 0;
   logic [21:0] ctl_now;

   assign ctl_now = {ALUOp, shiftOp, busOp, flagOp, immMUX, LUIOp, regWrite, memWrite,
                     flagWrite, pcAdd, pcJump, pcBranch, addrSel};

   // strobes = {immMUX, LUIOp, regWrite, memWrite, flagWrite, pcAdd, pcJump, pcBranch, addrSel}
   function automatic logic [21:0] mk(input logic [3:0] alu, input logic [1:0] sh,
                                      input logic [2:0] bus, input logic [3:0] flg,
                                      input logic [8:0] strobes);
      return {alu, sh, bus, flg, strobes};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation each time the DUT completes an instruction.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         idx = 0;
      end else if (pcAdd | pcJump | pcBranch) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got ctl 0x%0h, expected none", ctl_now);
         end else begin
            e = sb.pop_front();
            check($sformatf("ctl_%04h", e.word), 32'(ctl_now), 32'(e.ctl));
            check($sformatf("fields_%04h", e.word),
                  32'({instructionOp, immediate, regAddA, regAddB}),
                  32'({e.word[15:12], e.word[7:4], e.word[7:0], e.word[3:0], e.word[11:8]}));
            check($sformatf("latency_%04h", e.word), idx + 1, e.lat);
            check($sformatf("retired_%04h", e.word), 32'(retired), 32'(e.ret));
         end
         idx = 0;
      end else begin
         check("no_write_midinstr", 32'({regWrite, memWrite, flagWrite}), 32'd0);
         if (sb.size() > 0 && idx < 5)
            check($sformatf("addrsel_%04h_c%0d", sb[0].word, idx), 32'(addrSel),
                  32'(sb[0].amask[idx]));
         idx++;
         if (idx > 5) begin
            checks++;
            errors++;
            $display("FAIL stall: got %0d cycles without completion, expected at most 5", idx);
            idx = 0;
         end
      end
   end

   task automatic issue(input logic [15:0] w, input int lat, input logic [4:0] amask,
                        input logic [21:0] c);
      exp_t e;
      e.word  = w;
      e.lat   = lat;
      e.amask = amask;
      e.ctl   = c;
      e.ret   = model_ret;
      sb.push_back(e);
      model_ret = model_ret + 16'd1;
      memData = w;
      repeat (lat) @(posedge clk);
      #1;
   endtask

   logic [21:0] nop_ctl;
   logic [21:0] jal_ctl;

   initial begin
      nop_ctl = mk(4'h0, 2'b00, 3'd0, 4'h0, 9'b000001000);
`ifdef TRON_JAL_EN
      jal_ctl = mk(4'h0, 2'b00, 3'd4, 4'hE, 9'b001000100);
`else
      jal_ctl = nop_ctl;
`endif

      repeat (2) @(posedge clk);
      #1;
      check("reset_ctl", 32'(ctl_now), 32'd0);
      check("reset_fields", 32'({instructionOp, immediate, regAddA, regAddB}), 32'd0);
      check("reset_retired", 32'(retired), 32'd0);
      rst_n = 1'b1;

      issue(16'h0351, 3, 5'b00000, mk(4'h5, 2'b00, 3'd0, 4'h0, 9'b001011000)); // ADD R3,R1
      issue(16'h927F, 3, 5'b00000, mk(4'h9, 2'b00, 3'd0, 4'h0, 9'b101011000)); // SUBI
      issue(16'h04B5, 3, 5'b00000, mk(4'hB, 2'b00, 3'd0, 4'h0, 9'b000011000)); // CMP
      issue(16'hB40A, 3, 5'b00000, mk(4'hB, 2'b00, 3'd0, 4'h0, 9'b100011000)); // CMPI
      issue(16'h1AFF, 3, 5'b00000, mk(4'h1, 2'b00, 3'd0, 4'h0, 9'b101001000)); // ANDI
      issue(16'h07D2, 3, 5'b00000, mk(4'hD, 2'b00, 3'd0, 4'h0, 9'b001001000)); // MOV
      issue(16'hF5AB, 3, 5'b00000, mk(4'h0, 2'b00, 3'd3, 4'h0, 9'b111001000)); // LUI
      issue(16'h8301, 3, 5'b00000, mk(4'h0, 2'b01, 3'd1, 4'h0, 9'b101001000)); // LSHI
      issue(16'h8362, 3, 5'b00000, mk(4'h0, 2'b10, 3'd1, 4'h0, 9'b001001000)); // ASHU
      issue(16'h4205, 5, 5'b01100, mk(4'h0, 2'b00, 3'd2, 4'h0, 9'b001001000)); // LOAD
      issue(16'h4447, 3, 5'b00000, mk(4'h0, 2'b00, 3'd0, 4'h0, 9'b000101001)); // STOR
      issue(16'hC010, 3, 5'b00000, mk(4'h0, 2'b00, 3'd0, 4'h0, 9'b000000010)); // BEQ
      issue(16'hC1F0, 3, 5'b00000, mk(4'h0, 2'b00, 3'd0, 4'h1, 9'b000000010)); // BNE
      issue(16'h4EC3, 3, 5'b00000, mk(4'h0, 2'b00, 3'd0, 4'hE, 9'b000000100)); // JUC
      issue(16'h4486, 3, 5'b00000, jal_ctl);                                    // JAL
      issue(16'h6123, 3, 5'b00000, nop_ctl);                                    // undefined op
      issue(16'h0000, 3, 5'b00000, nop_ctl);                                    // R-type, bad ext
      issue(16'h4010, 3, 5'b00000, nop_ctl);                                    // special, bad ext
      issue(16'h8C55, 3, 5'b00000, nop_ctl);                                    // shift, bad ext
      issue(16'hE000, 3, 5'b00000, nop_ctl);                                    // undefined op

      // LOAD abandoned by reset while in MEM
      memData = 16'h4205;
      repeat (3) @(posedge clk);
      #1;
      check("abort_mem_addrsel", 32'(addrSel), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_ctl", 32'(ctl_now), 32'd0);
      check("abort_fields", 32'({instructionOp, immediate, regAddA, regAddB}), 32'd0);
      check("abort_retired", 32'(retired), 32'd0);
      model_ret = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      issue(16'h0351, 3, 5'b00000, mk(4'h5, 2'b00, 3'd0, 4'h0, 9'b001011000)); // ADD
      issue(16'h4447, 3, 5'b00000, mk(4'h0, 2'b00, 3'd0, 4'h0, 9'b000101001)); // STOR
      issue(16'h4205, 5, 5'b01100, mk(4'h0, 2'b00, 3'd2, 4'h0, 9'b001001000)); // LOAD

      check("scoreboard_drained", sb.size(), 32'd0);
      check("retired_final", 32'(retired), 32'(model_ret));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of stimulus, expected finish before 100us");
      $fatal(1);
   end

endmodule
